// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Parses ASCII commands from a UART RX FIFO and drives a simple memory bus.
//     R<ADDR_W/4 hex digits>  read memory, reply with DATA_W/4 uppercase hex chars
//     W<DATA_W/4 hex digits>  write memory at the address of the last R command
//   CR, LF and space between commands are ignored; any other byte is an error.
//
// Ports
//   clk, rst            system clock, asynchronous active-low reset
//   enable              allows a new command to start (a command in flight completes)
//   rx_empty, r_data    show-ahead RX FIFO; r_data valid while rx_empty=0
//   rd_uart             pops the byte presented on r_data
//   tx_full, w_data     TX FIFO status and push data
//   wr_uart             pushes w_data
//   mem_addr            address, driven from the addr register at all times
//   mem_re, mem_we      read / write strobes; read data valid the cycle after mem_re
//   mem_wdata, mem_rdata write / read data
//   busy                high whenever the parser is not idle
//   cmd_err             one-cycle pulse when an illegal byte is consumed
module uart_cmd_parser #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              rx_empty,
    input  logic [7:0]        r_data,
    output logic              rd_uart,
    input  logic              tx_full,
    output logic [7:0]        w_data,
    output logic              wr_uart,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] GET_ADDR = 3'd1;
    localparam logic [2:0] MEM_RD   = 3'd2;
    localparam logic [2:0] MEM_WAIT = 3'd3;
    localparam logic [2:0] SEND     = 3'd4;
    localparam logic [2:0] GET_DATA = 3'd5;
    localparam logic [2:0] MEM_WR   = 3'd6;

    localparam int ADDR_DIGITS = ADDR_W / 4;
    localparam int DATA_DIGITS = DATA_W / 4;
    localparam int MAX_DIGITS  = (ADDR_DIGITS > DATA_DIGITS) ? ADDR_DIGITS : DATA_DIGITS;
    localparam int CNT_W       = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_DIGITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_DIGITS - 1);

    localparam logic [7:0] CH_R  = 8'h52;  // 'R'
    localparam logic [7:0] CH_W  = 8'h57;  // 'W'
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_SP = 8'h20;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;      // committed address, only updated by a complete R
    logic [ADDR_W-1:0] addr_sh;   // digits of an R in progress
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] data_sh;   // read data being serialised in SEND
    logic [CNT_W-1:0]  cnt;

    logic              consume;
    logic              pop;
    logic              is_hex;
    logic [3:0]        nib;
    logic              byte_err;

    function automatic logic [7:0] to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
    endfunction

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        is_hex = 1'b1;
        nib    = 4'h0;
        if (r_data >= 8'h30 && r_data <= 8'h39) begin
            nib = r_data[3:0];
        end else if ((r_data >= 8'h41 && r_data <= 8'h46) ||
                     (r_data >= 8'h61 && r_data <= 8'h66)) begin
            nib = r_data[3:0] + 4'd9;
        end else begin
            is_hex = 1'b0;
        end
    end

    always_comb begin
        byte_err = 1'b0;
        case (state)
            IDLE:               byte_err = !(r_data == CH_R || r_data == CH_W ||
                                             r_data == CH_CR || r_data == CH_LF ||
                                             r_data == CH_SP);
            GET_ADDR, GET_DATA: byte_err = !is_hex;
            default:            byte_err = 1'b0;
        endcase
    end

    assign consume = (state == IDLE && enable) || state == GET_ADDR || state == GET_DATA;
    // rst gates the pop so the FIFO keeps its bytes while the parser is held in reset.
    assign pop     = rst && consume && !rx_empty;

    assign rd_uart   = pop;
    assign cmd_err   = pop && byte_err;
    assign wr_uart   = (state == SEND) && !tx_full;
    assign w_data    = (state == SEND) ? to_ascii(data_sh[DATA_W-1 -: 4]) : 8'h00;
    assign mem_re    = (state == MEM_RD);
    assign mem_we    = (state == MEM_WR);
    assign mem_addr  = addr;
    assign mem_wdata = wdata;
    assign busy      = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            addr    <= '0;
            addr_sh <= '0;
            wdata   <= '0;
            data_sh <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (pop) begin
                        if (r_data == CH_R)      state <= GET_ADDR;
                        else if (r_data == CH_W) state <= GET_DATA;
                    end
                end
                GET_ADDR: begin
                    if (pop) begin
                        if (!is_hex) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == ADDR_LAST) begin
                            addr  <= (addr_sh << 4) | ADDR_W'(nib);
                            cnt   <= '0;
                            state <= MEM_RD;
                        end else begin
                            addr_sh <= (addr_sh << 4) | ADDR_W'(nib);
                            cnt     <= cnt + 1'b1;
                        end
                    end
                end
                GET_DATA: begin
                    if (pop) begin
                        if (!is_hex) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            wdata <= (wdata << 4) | DATA_W'(nib);
                            if (cnt == DATA_LAST) begin
                                cnt   <= '0;
                                state <= MEM_WR;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                end
                MEM_RD:   state <= MEM_WAIT;
                MEM_WAIT: begin
                    data_sh <= mem_rdata;
                    cnt     <= '0;
                    state   <= SEND;
                end
                SEND: begin
                    // Shift only on an accepted push so w_data holds through a stall.
                    if (!tx_full) begin
                        data_sh <= data_sh << 4;
                        if (cnt == DATA_LAST) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                MEM_WR:   state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser
//   Directed bench for uart_cmd_parser: an RX FIFO model feeds command strings,
//   a small memory model answers reads and records writes, and a monitor
//   collects TX characters and bus strobes for comparison against
//   hand-computed expectations.
module tb_uart_cmd_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        rx_empty = 1'b1;
    logic [7:0]  r_data = 8'h00;
    logic        rd_uart;
    logic        tx_full;
    logic [7:0]  w_data;
    logic        wr_uart;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy;
    logic        cmd_err;

    uart_cmd_parser #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .tx_full   (tx_full),
        .w_data    (w_data),
        .wr_uart   (wr_uart),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // RX FIFO: stimulus owns the write side, the driver process owns the read side.
    logic [7:0] rx_buf [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    // Monitor state.
    logic        pop_pending = 1'b0;
    logic        rd_pending  = 1'b0;
    logic [15:0] rd_addr_q   = 16'h0;
    logic [7:0]  tx_q[$];
    int          tx_count   = 0;
    int          re_count   = 0;
    int          we_count   = 0;
    int          err_count  = 0;
    int          excl_bad   = 0;
    logic [15:0] re_addr    = 16'h0;
    logic [15:0] we_addr    = 16'h0;
    logic [31:0] we_data    = 32'h0;
    int          cyc        = 0;
    int          last_pop   = 0;
    int          re_pop     = 0;
    int          latency    = -1;
    logic        lat_armed  = 1'b0;
    logic [31:0] wmem [logic [15:0]];

    function automatic logic [31:0] mem_lookup(input logic [15:0] a);
        if (wmem.exists(a)) return wmem[a];
        case (a)
            16'h203E: return 32'h0000_0007;
            16'h0001: return 32'hCAFE_0001;
            16'hBEEF: return 32'hDEAD_BEEF;
            default:  return 32'h0000_0000;
        endcase
    endfunction

    // Driver: acts 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (pop_pending) rd_ptr = rd_ptr + 1;
        if (rd_pending) mem_rdata = mem_lookup(rd_addr_q);
        rx_empty = (rd_ptr == wr_ptr);
        r_data   = rx_empty ? 8'h00 : rx_buf[rd_ptr % 1024];
    end

    // Monitor: samples DUT outputs on the falling edge.
    always @(negedge clk) begin
        pop_pending = rst && rd_uart;
        rd_pending  = rst && mem_re;
        rd_addr_q   = mem_addr;
        if (rst) begin
            if (rd_uart) last_pop = cyc;
            if (wr_uart) begin
                tx_q.push_back(w_data);
                tx_count = tx_count + 1;
                if (lat_armed) begin
                    latency   = cyc - re_pop;
                    lat_armed = 1'b0;
                end
            end
            if (mem_re) begin
                re_count  = re_count + 1;
                re_addr   = mem_addr;
                re_pop    = last_pop;
                lat_armed = 1'b1;
            end
            if (mem_we) begin
                we_count = we_count + 1;
                we_addr  = mem_addr;
                we_data  = mem_wdata;
                wmem[mem_addr] = mem_wdata;
            end
            if (cmd_err) err_count = err_count + 1;
            if (32'(rd_uart) + 32'(wr_uart) + 32'(mem_re) + 32'(mem_we) > 1)
                excl_bad = excl_bad + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            rx_buf[wr_ptr % 1024] = s[i];
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        do begin
            step(1);
            k++;
        end while (!(rd_ptr == wr_ptr && !busy) && k < 400);
        check({tag, "_idle_timeout"}, 32'(k >= 400), 32'd0);
    endtask

    task automatic wait_tx(input string tag, input int n);
        int k = 0;
        while (tx_count < n && k < 400) begin
            step(1);
            k++;
        end
        check({tag, "_tx_timeout"}, 32'(tx_count >= n), 32'd1);
    endtask

    task automatic check_tx(input string tag, input int base, input string exp);
        int idx;
        check({tag, "_len"}, 32'(tx_count - base), 32'(exp.len()));
        for (int i = 0; i < exp.len(); i++) begin
            idx = base + i;
            check({tag, "_char"}, (idx < tx_q.size()) ? 32'(tx_q[idx]) : 32'h100, 32'(exp[i]));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_uart"},   32'(rd_uart),   32'd0);
        check({tag, "_wr_uart"},   32'(wr_uart),   32'd0);
        check({tag, "_mem_re"},    32'(mem_re),    32'd0);
        check({tag, "_mem_we"},    32'(mem_we),    32'd0);
        check({tag, "_cmd_err"},   32'(cmd_err),   32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_w_data"},    32'(w_data),    32'd0);
        check({tag, "_mem_wdata"}, mem_wdata,      32'd0);
        check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    endtask

    initial begin
        int base;
        int k;

        rst     = 1'b0;
        enable  = 1'b1;
        tx_full = 1'b0;
        // A byte waits in the FIFO during reset; it must not be popped.
        push_str("\n");
        step(3);
        check_outputs_zero("reset");
        rst = 1'b1;
        wait_idle("lf");
        check("lf_no_err", 32'(err_count), 32'd0);

        // Write with no prior read goes to address 0; mixed-case hex.
        push_str("W1234ABcd");
        wait_idle("w_noaddr");
        check("w_noaddr_we_count", 32'(we_count), 32'd1);
        check("w_noaddr_addr", 32'(we_addr), 32'h0000);
        check("w_noaddr_data", we_data, 32'h1234_ABCD);
        check("w_noaddr_no_tx", 32'(tx_count), 32'd0);

        // enable=0 holds off a new command; the command then runs normally.
        enable = 1'b0;
        push_str("R");
        step(6);
        check("en0_not_popped", 32'(wr_ptr - rd_ptr), 32'd1);
        check("en0_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        push_str("203E");
        base = tx_count;
        wait_tx("r203e", base + 8);
        check("r203e_busy_after_last", 32'(busy), 32'd0);
        wait_idle("r203e");
        check("r203e_re_count", 32'(re_count), 32'd1);
        check("r203e_re_addr", 32'(re_addr), 32'h203E);
        check_tx("r203e_tx", base, "00000007");
        check("r203e_latency", 32'(latency), 32'd3);

        // Whitespace is discarded; W uses the address of the last R.
        base = tx_count;
        push_str("\r\n W00000000");
        wait_idle("w203e");
        check("w203e_we_count", 32'(we_count), 32'd2);
        check("w203e_addr", 32'(we_addr), 32'h203E);
        check("w203e_data", we_data, 32'h0000_0000);
        check("w203e_no_tx", 32'(tx_count - base), 32'd0);
        check("w203e_no_err", 32'(err_count), 32'd0);

        // Illegal command byte, then an illegal digit mid-address.
        push_str("r");
        wait_idle("lower_r");
        check("lower_r_err", 32'(err_count), 32'd1);
        push_str("R20G");
        wait_idle("r20g");
        check("r20g_err", 32'(err_count), 32'd2);
        check("r20g_no_re", 32'(re_count), 32'd1);
        check("r20g_addr_kept", 32'(mem_addr), 32'h203E);
        base = tx_count;
        push_str("R0001");
        wait_tx("r0001", base + 8);
        wait_idle("r0001");
        check("r0001_re_addr", 32'(re_addr), 32'h0001);
        check_tx("r0001_tx", base, "CAFE0001");

        // TX back-pressure for 20 cycles after the first character.
        base = tx_count;
        push_str("RBEEF");
        wait_tx("beef_first", base + 1);
        tx_full = 1'b1;
        step(20);
        check("beef_stall_w_data", 32'(w_data), 32'h45);
        check("beef_stall_wr", 32'(wr_uart), 32'd0);
        check("beef_stall_count", 32'(tx_count - base), 32'd1);
        tx_full = 1'b0;
        wait_tx("beef", base + 8);
        wait_idle("beef");
        check_tx("beef_tx", base, "DEADBEEF");

        // Reset in the middle of a W command.
        base = tx_count;
        push_str("W1234");
        k = 0;
        while (rd_ptr != wr_ptr && k < 100) begin
            step(1);
            k++;
        end
        step(1);
        check("rstmid_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_outputs_zero("rstmid");
        step(2);
        rst = 1'b1;
        step(5);
        check("rstmid_no_we", 32'(we_count), 32'd2);
        check("rstmid_no_tx", 32'(tx_count - base), 32'd0);
        check("rstmid_idle", 32'(busy), 32'd0);

        // Next read runs normally; enable drops mid-command without effect.
        push_str("R0000");
        k = 0;
        while (!busy && k < 100) begin
            step(1);
            k++;
        end
        enable = 1'b0;
        wait_tx("r0000", base + 8);
        wait_idle("r0000");
        enable = 1'b1;
        check("r0000_re_addr", 32'(re_addr), 32'h0000);
        check_tx("r0000_tx", base, "1234ABCD");

        check("exclusive_strobes", 32'(excl_bad), 32'd0);
        check("total_errors", 32'(err_count), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
